// File: rtl/raid_pkg.sv
// Shared types for the disk clear/restore sweep controller.
package raid_pkg;

  // Width of a disk index; the array holds at most 2**DISK_W disks.
  localparam int DISK_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RD,
    WR,
    NEXT,
    DONE
  } state_t;

  // Restore is the reset mode, so it takes encoding 0.
  typedef enum logic {
    MODE_RESTORE = 1'b0,
    MODE_CLEAR   = 1'b1
  } mode_t;

endpackage

// File: rtl/parity_accum.sv
// XOR parity accumulator: synchronous load-zero, accumulate on enable.
module parity_accum #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] acc
);

  // Clear wins over accumulate so a new block always starts from zero.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/disk_rebuild_ctrl.sv
// Sweep controller for disk clear and disk restore. Drives the external
// block counter (enable/clear) and uses its count as the block address.
// Restore: read every surviving disk, XOR the words, write the parity to the
// target disk. Clear: write zeros to the target disk.
module disk_rebuild_ctrl
  import raid_pkg::*;
#(
  parameter int NUM_DISKS = 4,
  parameter int DATA_W    = 32,
  parameter int BLK_W     = 11
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start_restore,
  input  logic              start_clear,
  input  logic [DISK_W-1:0] tgt_disk,
  input  logic              abort,
  input  logic [BLK_W-1:0]  block_no,
  input  logic              blk_rollover,
  output logic              cnt_enable,
  output logic              cnt_clear,
  output logic              rd_req,
  output logic [DISK_W-1:0] rd_disk,
  output logic [BLK_W-1:0]  rd_addr,
  input  logic              rd_ack,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_req,
  output logic [DISK_W-1:0] wr_disk,
  output logic [BLK_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_t              state;
  mode_t               mode_q;
  logic [DISK_W-1:0]   tgt_q;
  logic [DATA_W-1:0]   acc;
  logic                acc_clr;
  logic                acc_en;
  logic [DISK_W:0]     nx_src;
  logic                src_last;
  logic [DISK_W-1:0]   first_src;

  // Next surviving disk after cur, skipping the target; one extra bit so
  // running past the last disk is visible.
  function automatic logic [DISK_W:0] next_src(input logic [DISK_W:0]   cur,
                                               input logic [DISK_W-1:0] tgt);
    logic [DISK_W:0] n;
    n = cur + 1'b1;
    if (n == {1'b0, tgt}) n = n + 1'b1;
    return n;
  endfunction

  // Source sequencing: first survivor and successor of the current one.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    first_src = '0;
    if (tgt_q == '0) first_src = DISK_W'(1);
    nx_src   = next_src({1'b0, rd_disk}, tgt_q);
    src_last = (int'(nx_src) >= NUM_DISKS);
  end

  // Accumulator restarts at sweep start and between blocks; an aborted read
  // never reaches it.
  assign acc_clr = (state == INIT) || (state == NEXT);
  assign acc_en  = (state == RD) && rd_req && rd_ack && !abort;

  parity_accum #(.DATA_W(DATA_W)) u_parity_accum (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (rd_data),
    .acc   (acc)
  );

  // Addresses follow the counter directly; it only moves during NEXT, so
  // they are stable for the whole life of a request.
  assign rd_addr = rd_req ? block_no : '0;
  assign wr_addr = wr_req ? block_no : '0;
  assign wr_disk = wr_req ? tgt_q : '0;
  assign wr_data = (wr_req && mode_q == MODE_RESTORE) ? acc : '0;

  // Sweep FSM with registered requests, counter strobes and status pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      mode_q     <= MODE_RESTORE;
      tgt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cnt_enable <= 1'b0;
      cnt_clear  <= 1'b0;
      rd_req     <= 1'b0;
      rd_disk    <= '0;
      wr_req     <= 1'b0;
    end else begin
      cnt_enable <= 1'b0;
      cnt_clear  <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      if (abort && state != IDLE) begin
        // Abort beats any same-cycle ack: nothing is accumulated or counted.
        state   <= IDLE;
        busy    <= 1'b0;
        rd_req  <= 1'b0;
        rd_disk <= '0;
        wr_req  <= 1'b0;
        err     <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start_restore || start_clear) begin
              tgt_q  <= tgt_disk;
              mode_q <= start_restore ? MODE_RESTORE : MODE_CLEAR;
              if (int'(tgt_disk) >= NUM_DISKS) begin
                err <= 1'b1;
              end else begin
                state     <= INIT;
                busy      <= 1'b1;
                cnt_clear <= 1'b1;
              end
            end
          end
          INIT: begin
            if (mode_q == MODE_RESTORE) begin
              state   <= RD;
              rd_req  <= 1'b1;
              rd_disk <= first_src;
            end else begin
              state  <= WR;
              wr_req <= 1'b1;
            end
          end
          RD: begin
            // rd_req stays up across sources; only rd_disk moves.
            if (rd_req && rd_ack) begin
              if (src_last) begin
                state   <= WR;
                rd_req  <= 1'b0;
                rd_disk <= '0;
                wr_req  <= 1'b1;
              end else begin
                rd_disk <= nx_src[DISK_W-1:0];
              end
            end
          end
          WR: begin
            // blk_rollover cannot change before NEXT, so deciding the advance
            // here puts the cnt_enable pulse inside NEXT and the counter has
            // moved by the time the next block's request rises.
            if (wr_req && wr_ack) begin
              state      <= NEXT;
              wr_req     <= 1'b0;
              cnt_enable <= !blk_rollover;
            end
          end
          NEXT: begin
            if (blk_rollover) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (mode_q == MODE_RESTORE) begin
              state   <= RD;
              rd_req  <= 1'b1;
              rd_disk <= first_src;
            end else begin
              state  <= WR;
              wr_req <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disk_rebuild_ctrl.sv
// Self-checking bench for disk_rebuild_ctrl: block-counter model, disk
// responders with programmable/random ack latency, and a transaction-level
// reference of the expected read/write stream.
module tb_disk_rebuild_ctrl;

  localparam int NUM_DISKS = 4;
  localparam int DATA_W    = 32;
  localparam int BLK_W     = 11;
  localparam int ROLL      = 2000;

  typedef struct packed {
    logic        is_wr;
    logic [1:0]  disk;
    logic [10:0] addr;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              n_rst;
  logic              start_restore, start_clear, abort = 1'b0;
  logic [1:0]        tgt_disk;
  logic [BLK_W-1:0]  block_no;
  logic              blk_rollover;
  logic              cnt_enable, cnt_clear;
  logic              rd_req, wr_req, rd_ack = 1'b0, wr_ack = 1'b0;
  logic [1:0]        rd_disk, wr_disk;
  logic [BLK_W-1:0]  rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data = '0, wr_data;
  logic              busy, done, err;

  // Second instance with a 3-disk array for the illegal-target path.
  logic              s3_restore, s3_clear, s3_abort, s3_roll, s3_rd_ack, s3_wr_ack;
  logic [1:0]        s3_tgt;
  logic [BLK_W-1:0]  s3_blk;
  logic [DATA_W-1:0] s3_rd_data;
  logic              s3_cnt_en, s3_cnt_clr, s3_rd_req, s3_wr_req, s3_busy, s3_done, s3_err;
  logic [1:0]        s3_rd_disk, s3_wr_disk;
  logic [BLK_W-1:0]  s3_rd_addr, s3_wr_addr;
  logic [DATA_W-1:0] s3_wr_data;

  disk_rebuild_ctrl #(.NUM_DISKS(NUM_DISKS), .DATA_W(DATA_W), .BLK_W(BLK_W)) dut (
    .clk(clk), .n_rst(n_rst), .start_restore(start_restore), .start_clear(start_clear),
    .tgt_disk(tgt_disk), .abort(abort), .block_no(block_no), .blk_rollover(blk_rollover),
    .cnt_enable(cnt_enable), .cnt_clear(cnt_clear), .rd_req(rd_req), .rd_disk(rd_disk),
    .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data), .wr_req(wr_req),
    .wr_disk(wr_disk), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .busy(busy), .done(done), .err(err)
  );

  disk_rebuild_ctrl #(.NUM_DISKS(3), .DATA_W(DATA_W), .BLK_W(BLK_W)) dut3 (
    .clk(clk), .n_rst(n_rst), .start_restore(s3_restore), .start_clear(s3_clear),
    .tgt_disk(s3_tgt), .abort(s3_abort), .block_no(s3_blk), .blk_rollover(s3_roll),
    .cnt_enable(s3_cnt_en), .cnt_clear(s3_cnt_clr), .rd_req(s3_rd_req), .rd_disk(s3_rd_disk),
    .rd_addr(s3_rd_addr), .rd_ack(s3_rd_ack), .rd_data(s3_rd_data), .wr_req(s3_wr_req),
    .wr_disk(s3_wr_disk), .wr_addr(s3_wr_addr), .wr_data(s3_wr_data), .wr_ack(s3_wr_ack),
    .busy(s3_busy), .done(s3_done), .err(s3_err)
  );

  // Block counter model: clear, advance, roll over after ROLL.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)               block_no <= '0;
    else if (cnt_clear)       block_no <= '0;
    else if (cnt_enable)      block_no <= (block_no == BLK_W'(ROLL)) ? '0 : block_no + 11'd1;
  end
  assign blk_rollover = (block_no == BLK_W'(ROLL));

  // Disk contents: fixed per-disk words or a seeded hash of (disk, block).
  logic [31:0] fixed_pat [4];
  bit          use_fixed = 1'b0;
  logic [31:0] seed = 32'h1;

  function automatic logic [31:0] disk_word(input logic [1:0] d, input logic [10:0] a);
    logic [31:0] x;
    if (use_fixed) return fixed_pat[d];
    x = seed ^ ({30'd0, d} * 32'h9E3779B9) ^ ({21'd0, a} * 32'h85EBCA6B);
    x = x ^ (x >> 15);
    x = x * 32'h2C1B3C6D;
    x = x ^ (x >> 12);
    return x;
  endfunction

  // Responder configuration (written by the main sequence only).
  int rd_lat_max = 0, wr_lat_max = 0, abort_tx_abs = -1;
  bit rnd_lat = 1'b0;

  // Monitor state (written by the negedge process only).
  int   n_clr = 0, n_en = 0, n_en_bad = 0, n_done = 0, n_err = 0, n_post_ok = 0;
  int   n_unstable = 0, tx_count = 0;
  int   rd_wait = 0, wr_wait = 0, rd_lat = 0, wr_lat = 0;
  bit   post_pending = 1'b0;
  logic [12:0] rd_hold;
  logic [44:0] wr_hold;
  ev_t  ev_log [$];
  logic wr_acc_q = 1'b0;

  always @(posedge clk) wr_acc_q <= wr_req && wr_ack && !abort;

  // Monitors and disk responders, evaluated away from the active edge.
  always @(negedge clk) begin
    ev_t e;
    if (cnt_clear) n_clr++;
    if (cnt_enable) begin
      n_en++;
      if (!wr_acc_q) n_en_bad++;
    end
    if (done) n_done++;
    if (err)  n_err++;
    if (post_pending) begin
      if (!busy && !rd_req && !wr_req && err) n_post_ok++;
      post_pending = 1'b0;
    end
    abort = 1'b0;

    if (rd_ack) begin rd_ack = 1'b0; rd_wait = 0; end
    if (rd_req) begin
      if (rd_wait == 0) begin
        rd_hold = {rd_disk, rd_addr};
        rd_lat  = rnd_lat ? int'($urandom_range(rd_lat_max, 0)) : rd_lat_max;
      end else if ({rd_disk, rd_addr} !== rd_hold) n_unstable++;
      if (rd_wait >= rd_lat) begin
        rd_ack  = 1'b1;
        rd_data = disk_word(rd_disk, rd_addr);
        if (tx_count == abort_tx_abs) begin
          abort = 1'b1; post_pending = 1'b1;
        end else begin
          e = '{is_wr: 1'b0, disk: rd_disk, addr: rd_addr, data: 32'd0};
          ev_log.push_back(e);
        end
        tx_count++;
      end else rd_wait++;
    end else rd_wait = 0;

    if (wr_ack) begin wr_ack = 1'b0; wr_wait = 0; end
    if (wr_req) begin
      if (wr_wait == 0) begin
        wr_hold = {wr_disk, wr_addr, wr_data};
        wr_lat  = rnd_lat ? int'($urandom_range(wr_lat_max, 0)) : wr_lat_max;
      end else if ({wr_disk, wr_addr, wr_data} !== wr_hold) n_unstable++;
      if (wr_wait >= wr_lat) begin
        wr_ack = 1'b1;
        if (tx_count == abort_tx_abs) begin
          abort = 1'b1; post_pending = 1'b1;
        end else begin
          e = '{is_wr: 1'b1, disk: wr_disk, addr: wr_addr, data: wr_data};
          ev_log.push_back(e);
        end
        tx_count++;
      end else wr_wait++;
    end else wr_wait = 0;
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sweep: start it, wait (bounded) for busy to fall, then compare the
  // observed transaction stream and pulse counts with the reference.
  // abort_rel >= 0 aborts on that ack (counted from the sweep start).
  task automatic run_sweep(input string tag, input bit sr, input bit sc, input logic [1:0] t,
                           input int rl, input int wl, input bit rnd, input int abort_rel,
                           input int inject_cyc, input int max_cyc);
    int   base_log, c_clr, c_en, c_bad, c_done, c_err, c_post, c_unst, cyc, n_got, n_exp, adv;
    bit   restore, aborted;
    logic [31:0] acc;
    ev_t  exp_q [$];
    base_log = ev_log.size();
    c_clr = n_clr; c_en = n_en; c_bad = n_en_bad; c_done = n_done; c_err = n_err;
    c_post = n_post_ok; c_unst = n_unstable;
    rd_lat_max = rl; wr_lat_max = wl; rnd_lat = rnd;
    abort_tx_abs = (abort_rel < 0) ? -1 : tx_count + abort_rel;
    @(negedge clk);
    start_restore = sr; start_clear = sc; tgt_disk = t;
    @(negedge clk);
    start_restore = 1'b0; start_clear = 1'b0;
    cyc = 0;
    while (busy && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      start_restore = (cyc == inject_cyc);
      tgt_disk      = (cyc == inject_cyc) ? t ^ 2'd1 : t;
    end
    start_restore = 1'b0;
    if (cyc >= max_cyc) check({tag, "_timeout"}, 64'd1, 64'd0);
    repeat (3) @(negedge clk);
    abort_tx_abs = -1;

    restore = sr;
    aborted = (abort_rel >= 0);
    for (int b = 0; b <= ROLL; b++) begin
      acc = '0;
      if (restore) begin
        for (int d = 0; d < NUM_DISKS; d++) begin
          if (d != int'(t)) begin
            exp_q.push_back('{is_wr: 1'b0, disk: 2'(d), addr: 11'(b), data: 32'd0});
            acc ^= disk_word(2'(d), 11'(b));
          end
        end
      end
      exp_q.push_back('{is_wr: 1'b1, disk: t, addr: 11'(b), data: restore ? acc : 32'd0});
      if (aborted && exp_q.size() > abort_rel) break;
    end
    n_exp = aborted ? abort_rel : exp_q.size();
    n_got = ev_log.size() - base_log;
    check({tag, "_tx_count"}, 64'(n_got), 64'(n_exp));
    for (int i = 0; i < n_got && i < n_exp; i++)
      check({tag, "_tx"}, 64'(ev_log[base_log + i]), 64'(exp_q[i]));

    adv = aborted ? abort_rel / (restore ? NUM_DISKS : 1) : ROLL;
    check({tag, "_cnt_clear"},  64'(n_clr - c_clr), 64'd1);
    check({tag, "_cnt_enable"}, 64'(n_en - c_en), 64'(adv));
    check({tag, "_en_no_ack"},  64'(n_en_bad - c_bad), 64'd0);
    check({tag, "_done"},       64'(n_done - c_done), aborted ? 64'd0 : 64'd1);
    check({tag, "_err"},        64'(n_err - c_err), aborted ? 64'd1 : 64'd0);
    check({tag, "_stable"},     64'(n_unstable - c_unst), 64'd0);
    if (aborted) check({tag, "_abort_idle"}, 64'(n_post_ok - c_post), 64'd1);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  int   sr_r, t_r, abort_r, c_done0, c_err0;
  logic quiet;

  initial begin
    n_rst = 1'b0; start_restore = 1'b0; start_clear = 1'b0; tgt_disk = 2'd0;
    s3_restore = 1'b0; s3_clear = 1'b0; s3_tgt = 2'd0; s3_abort = 1'b0; s3_roll = 1'b0;
    s3_rd_ack = 1'b0; s3_wr_ack = 1'b0; s3_blk = '0; s3_rd_data = '0;
    fixed_pat[0] = 32'hA5A5A5A5; fixed_pat[1] = 32'h12345678;
    fixed_pat[2] = 32'h0F0F0F0F; fixed_pat[3] = 32'hFFFF0000;
    repeat (3) @(negedge clk);
    check("rst_ctl", 64'({cnt_enable, cnt_clear, rd_req, wr_req, busy, done, err, rd_disk, wr_disk}), 64'd0);
    check("rst_addr", 64'({rd_addr, wr_addr}), 64'd0);
    check("rst_wdata", 64'(wr_data), 64'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Illegal target on a 3-disk array: err pulse, nothing else moves.
    s3_clear = 1'b1; s3_tgt = 2'd3;
    @(negedge clk);
    s3_clear = 1'b0;
    check("d3_clear_err", 64'(s3_err), 64'd1);
    check("d3_clear_busy", 64'(s3_busy), 64'd0);
    quiet = 1'b0;
    repeat (3) begin
      @(negedge clk);
      quiet |= s3_rd_req | s3_wr_req | s3_busy | s3_cnt_clr | s3_err;
    end
    check("d3_quiet", 64'(quiet), 64'd0);
    s3_restore = 1'b1; s3_tgt = 2'd3;
    @(negedge clk);
    s3_restore = 1'b0;
    check("d3_restore_err", 64'(s3_err), 64'd1);
    check("d3_restore_req", 64'({s3_rd_req, s3_wr_req, s3_busy}), 64'd0);

    // Full clear sweep, zero-wait, with a start pulse injected mid-sweep.
    use_fixed = 1'b0; seed = $urandom;
    run_sweep("clear_t2", 1'b0, 1'b1, 2'd2, 0, 0, 1'b0, -1, 50, 10000);

    // Full restore sweep, zero-wait, fixed per-disk words.
    use_fixed = 1'b1;
    run_sweep("restore_t1", 1'b1, 1'b0, 2'd1, 0, 0, 1'b0, -1, -1, 15000);

    // Full restore sweep with 3-cycle read and 5-cycle write acks.
    use_fixed = 1'b0; seed = $urandom;
    run_sweep("restore_slow", 1'b1, 1'b0, 2'd1, 3, 5, 1'b0, -1, -1, 45000);

    // Abort coinciding with the write ack of block 7.
    run_sweep("abort_wr7", 1'b1, 1'b0, 2'd3, 1, 2, 1'b0, 7 * NUM_DISKS + 3, -1, 2000);

    // Both starts together: restore wins, first read goes to disk 1.
    run_sweep("both_start", 1'b1, 1'b1, 2'd0, 0, 0, 1'b0, 2, -1, 500);

    // Random mode, target, latencies and abort point.
    for (int k = 0; k < 6; k++) begin
      sr_r    = int'($urandom_range(1, 0));
      t_r     = int'($urandom_range(3, 0));
      abort_r = int'($urandom_range(12 * (sr_r != 0 ? NUM_DISKS : 1) - 1, 1));
      seed    = $urandom;
      run_sweep("random", sr_r[0], !sr_r[0], 2'(t_r), 2, 3, 1'b1, abort_r, -1, 2000);
    end

    // Reset mid-sweep: outputs drop at once, no done or err.
    c_done0 = n_done; c_err0 = n_err;
    @(negedge clk);
    start_clear = 1'b1; tgt_disk = 2'd0;
    @(negedge clk);
    start_clear = 1'b0;
    repeat (30) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("midrst_ctl", 64'({cnt_enable, cnt_clear, rd_req, wr_req, busy, done, err}), 64'd0);
    check("midrst_wr", 64'({wr_disk, wr_addr, wr_data}), 64'd0);
    repeat (3) @(negedge clk);
    check("midrst_pulses", 64'({n_done - c_done0, n_err - c_err0}), 64'd0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
